ps2_kbd_ctrl: RTL
=================

# ps2_kbd_ctrl

Keyboard scan-code controller sitting directly downstream of Ps2_Rx. It enables the receiver and consumes each received byte. It folds the PS/2 Set-2 prefixes 0xE0 (extended) and 0xF0 (break) into single key events, which it stores in a small first-word-fall-through FIFO read by the application logic. A watchdog discards a dangling prefix when the follow-up byte never arrives.

## Interface
Parameters:
- FIFO_AW, 2: FIFO address width; depth = 2**FIFO_AW entries (4).
- TIMEOUT_CYCLES, 500000: prefix-wait limit in clk cycles (10 ms at 50 MHz).
- TO_W, 20: watchdog counter width; must satisfy 2**TO_W > TIMEOUT_CYCLES.

Ports:
- clk_kbd_ctrl  in  1  system clock, rising edge.
- reset_kbd_ctrl  in  1  asynchronous, active-low reset.
- enable_kbd_ctrl  in  1  controller enable; 0 forces IDLE, ignores bytes, deasserts receiver enable.
- rx_done_tick_kbd_ctrl  in  1  one-cycle strobe from Ps2_Rx, byte valid.
- dout_kbd_ctrl  in  8  received byte from Ps2_Rx, valid with the strobe.
- rx_en_kbd_ctrl  out  1  receiver enable to Ps2_Rx; registered copy of enable_kbd_ctrl.
- rd_kbd_ctrl  in  1  pop strobe for FIFO head.
- key_code_kbd_ctrl  out  8  head entry scan code.
- key_ext_kbd_ctrl  out  1  head entry was E0-prefixed.
- key_break_kbd_ctrl  out  1  head entry is a release (F0-prefixed).
- empty_kbd_ctrl  out  1  FIFO empty.
- full_kbd_ctrl  out  1  FIFO full.
- overflow_kbd_ctrl  out  1  sticky, event dropped on full FIFO.
- timeout_tick_kbd_ctrl  out  1  one-cycle pulse, prefix discarded by watchdog.

## Operation
- The decoder FSM has four states: IDLE, EXT (0xE0 seen), BRK (0xF0 seen), EXT_BRK (0xE0 then 0xF0 seen). Bytes are processed only on cycles with rx_done_tick=1 and enable=1.
- Transitions from IDLE:
  - 0xE0 → EXT.
  - 0xF0 → BRK.
  - Any other byte: push {ext=0, brk=0, code}, stay in IDLE.
- Transitions from EXT:
  - 0xF0 → EXT_BRK.
  - 0xE0 → stay in EXT.
  - Any other byte: push {1, 0, code} → IDLE.
- Transitions from BRK:
  - 0xE0 → EXT_BRK.
  - 0xF0 → stay in BRK.
  - Any other byte: push {0, 1, code} → IDLE.
- Transitions from EXT_BRK:
  - 0xE0 or 0xF0 → stay in EXT_BRK.
  - Any other byte: push {1, 1, code} → IDLE.
- Only 0xE0 and 0xF0 are prefixes. All other bytes, including 0xAA, 0xFA and 0xE1, are stored as plain codes.
- Watchdog:
  - A TO_W-bit counter clears on every accepted byte and while in IDLE, and increments in the other three states.
  - On reaching TIMEOUT_CYCLES-1, the FSM goes to IDLE and timeout_tick pulses for that cycle. Nothing is pushed.
- FIFO: 10-bit entries {ext, brk, code}, binary read/write pointers plus an occupancy count.
  - Push while full without a simultaneous pop: the entry is dropped and overflow is set.
  - Push and pop in the same cycle while full: both happen, no overflow.
  - Pop while empty: ignored.
  - Pointers wrap modulo depth.
- enable=0: FSM goes to IDLE and the watchdog clears. FIFO contents and overflow are retained, and reads still work. Incoming ticks are ignored.
- overflow is cleared only by reset.

## Timing
- Reset values (all outputs): rx_en=0, key_code=0x00, key_ext=0, key_break=0, empty=1, full=0, overflow=0, timeout_tick=0. On reset the FSM goes to IDLE, and pointers and counter go to 0.
- Reset assertion mid-frame or mid-prefix clears everything immediately; no event is emitted.
- rx_en follows enable with a 1-cycle latency.
- A terminating byte strobed at cycle N makes the entry visible at cycle N+1: empty falls, or the head updates if the FIFO was empty.
- Head outputs are driven combinationally from mem[rd_ptr] (first-word-fall-through). rd at cycle M advances the head at M+1.
- full and empty are registered from the occupancy count and are valid the cycle after the push or pop.
- Timeout: the last byte arrives at cycle N and the FSM is in a prefix state. timeout_tick pulses at N+TIMEOUT_CYCLES, when the counter reaches TIMEOUT_CYCLES-1 (counter is 0 at N+1), and the FSM is in IDLE the following cycle.
- Ticks arriving on consecutive cycles are each processed; there is no minimum spacing.

## Test plan
- Reset, enable=1, strobe 0x1C → one entry {code=0x1C, ext=0, brk=0}. empty=0 at the next cycle; after rd, empty=1.
- Strobe F0,1C then E0,75 then E0,F0,75 → three entries in order: {1C,0,1}, {75,1,0}, {75,1,1}.
- Strobe 5 plain codes 0x10..0x14 with no reads → full=1 after the 4th, overflow=1 after the 5th; reads return 0x10..0x13. Push and pop in the same cycle while full leaves overflow unchanged.
- TIMEOUT_CYCLES=16: strobe E0, then wait → timeout_tick pulses exactly 16 cycles after the strobe. A subsequent 0x1C yields {1C,0,0}.
- Strobe F0, drop enable for 1 cycle, re-enable, strobe 0x1C → entry {1C,0,0}. rx_en lags enable by 1 cycle; a tick arriving while enable=0 is ignored.
- Assert reset mid-sequence (after E0, with 2 entries queued) → all outputs return to reset values asynchronously; no entry is emitted afterwards for the pending prefix.

Source files
------------

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl
//   PS/2 Set-2 scan-code controller placed after Ps2_Rx. It enables the
//   receiver and folds the 0xE0 (extended) and 0xF0 (break) prefixes into
//   single key events. Each event is queued in a small first-word-fall-through
//   FIFO. A watchdog drops a prefix whose follow-up byte never arrives.
//
// Ports
//   clk_kbd_ctrl           system clock, rising edge
//   reset_kbd_ctrl         asynchronous active-low reset
//   enable_kbd_ctrl        controller enable (0: decoder idle, bytes ignored)
//   rx_done_tick_kbd_ctrl  byte-valid strobe from Ps2_Rx
//   dout_kbd_ctrl          received byte from Ps2_Rx
//   rx_en_kbd_ctrl         registered receiver enable to Ps2_Rx
//   rd_kbd_ctrl            pop strobe for the FIFO head
//   key_code_kbd_ctrl      head entry scan code
//   key_ext_kbd_ctrl       head entry was E0-prefixed
//   key_break_kbd_ctrl     head entry is a release (F0-prefixed)
//   empty_kbd_ctrl         FIFO empty
//   full_kbd_ctrl          FIFO full
//   overflow_kbd_ctrl      sticky: an event was dropped on a full FIFO
//   timeout_tick_kbd_ctrl  one-cycle pulse when the watchdog drops a prefix
module ps2_kbd_ctrl #(
    parameter int unsigned FIFO_AW        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter int unsigned TO_W           = 20
) (
    input  logic       clk_kbd_ctrl,
    input  logic       reset_kbd_ctrl,
    input  logic       enable_kbd_ctrl,
    input  logic       rx_done_tick_kbd_ctrl,
    input  logic [7:0] dout_kbd_ctrl,
    output logic       rx_en_kbd_ctrl,
    input  logic       rd_kbd_ctrl,
    output logic [7:0] key_code_kbd_ctrl,
    output logic       key_ext_kbd_ctrl,
    output logic       key_break_kbd_ctrl,
    output logic       empty_kbd_ctrl,
    output logic       full_kbd_ctrl,
    output logic       overflow_kbd_ctrl,
    output logic       timeout_tick_kbd_ctrl
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_t;

    state_t             state, state_nxt;
    logic               accept;
    logic               push;
    logic [9:0]         push_data;
    logic               timeout;
    logic [TO_W-1:0]    wd_cnt;

    logic [9:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count, count_nxt;
    logic               fifo_full_now;
    logic               do_push, do_pop;

    assign accept = rx_done_tick_kbd_ctrl & enable_kbd_ctrl;

    // ---------------- decoder FSM ----------------
    always_ff @(posedge clk_kbd_ctrl or negedge reset_kbd_ctrl) begin
        if (!reset_kbd_ctrl) state <= IDLE;
        else                 state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_data = {2'b00, dout_kbd_ctrl};
        timeout   = 1'b0;
        if (!enable_kbd_ctrl) begin
            state_nxt = IDLE;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (dout_kbd_ctrl == 8'hE0)      state_nxt = EXT;
                    else if (dout_kbd_ctrl == 8'hF0) state_nxt = BRK;
                    else                             push = 1'b1;
                end
                EXT: begin
                    if (dout_kbd_ctrl == 8'hF0) state_nxt = EXT_BRK;
                    else if (dout_kbd_ctrl != 8'hE0) begin
                        push      = 1'b1;
                        push_data = {2'b10, dout_kbd_ctrl};
                        state_nxt = IDLE;
                    end
                end
                BRK: begin
                    if (dout_kbd_ctrl == 8'hE0) state_nxt = EXT_BRK;
                    else if (dout_kbd_ctrl != 8'hF0) begin
                        push      = 1'b1;
                        push_data = {2'b01, dout_kbd_ctrl};
                        state_nxt = IDLE;
                    end
                end
                EXT_BRK: begin
                    if (dout_kbd_ctrl != 8'hE0 && dout_kbd_ctrl != 8'hF0) begin
                        push      = 1'b1;
                        push_data = {2'b11, dout_kbd_ctrl};
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE && wd_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            // A byte landing on the expiry cycle wins; the prefix is kept.
            timeout   = 1'b1;
            state_nxt = IDLE;
        end
    end

    assign timeout_tick_kbd_ctrl = timeout;

    // ---------------- watchdog ----------------
    always_ff @(posedge clk_kbd_ctrl or negedge reset_kbd_ctrl) begin
        if (!reset_kbd_ctrl)
            wd_cnt <= '0;
        else if (!enable_kbd_ctrl || accept || state == IDLE || timeout)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + TO_W'(1);
    end

    // ---------------- receiver enable ----------------
    always_ff @(posedge clk_kbd_ctrl or negedge reset_kbd_ctrl) begin
        if (!reset_kbd_ctrl) rx_en_kbd_ctrl <= 1'b0;
        else                 rx_en_kbd_ctrl <= enable_kbd_ctrl;
    end

    // ---------------- event FIFO ----------------
    // A pop frees the slot in the same cycle, so a push into a full FIFO is
    // accepted when it coincides with a pop.
    assign fifo_full_now = (count == (FIFO_AW+1)'(DEPTH));
    assign do_pop        = rd_kbd_ctrl & (count != '0);
    assign do_push       = push & (~fifo_full_now | do_pop);

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop)      count_nxt = count + (FIFO_AW+1)'(1);
        else if (!do_push && do_pop) count_nxt = count - (FIFO_AW+1)'(1);
    end

    always_ff @(posedge clk_kbd_ctrl or negedge reset_kbd_ctrl) begin
        if (!reset_kbd_ctrl) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            empty_kbd_ctrl    <= 1'b1;
            full_kbd_ctrl     <= 1'b0;
            overflow_kbd_ctrl <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + FIFO_AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
            if (push && fifo_full_now && !do_pop) overflow_kbd_ctrl <= 1'b1;
            count          <= count_nxt;
            empty_kbd_ctrl <= (count_nxt == '0);
            full_kbd_ctrl  <= (count_nxt == (FIFO_AW+1)'(DEPTH));
        end
    end

    assign {key_ext_kbd_ctrl, key_break_kbd_ctrl, key_code_kbd_ctrl} = mem[rd_ptr];

endmodule
